econet_hdlc_tx: RTL and testbench

// - Parametrised Econet HDLC frame transmitter; successor to the fixed-function serial-fed TX path.
// - Accepts bytes from the MCU-side bridge through a FIFO with valid/ready and a last marker.
// - Emits opening flags, bit-stuffed data, an optional CRC-16 FCS and a closing flag.
// - Clocks bits on the line from the externally supplied Econet clock; supports abort and underrun.

---
 rtl/econet_hdlc_tx.sv | 257 +++++++++++++++++++++++++
 tb/tb_econet_hdlc_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/econet_hdlc_tx.sv
// Econet HDLC frame transmitter: byte FIFO in, flag/stuffed data/optional CRC-16 FCS out,
// bits advanced on the falling edge of the externally supplied Econet clock.
module econet_hdlc_tx #(
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int PREAMBLE_FLAGS = 1,
  parameter int APPEND_FCS     = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       tx_abort,
  input  logic       econet_clock_R,
  output logic       econet_data_D,
  output logic       econet_data_DE,
  output logic       busy,
  output logic       underrun
);

  localparam int         AW   = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [7:0] FLAG = 8'h7E;

  typedef enum logic [2:0] {
    S_IDLE, S_OPEN, S_DATA, S_FCS, S_CLOSE, S_ABORT
  } state_t;

  // Econet clock synchroniser and falling-edge detect
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   w_tick;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], econet_clock_R};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_tick = r_hist & ~r_sync[SYNC_STAGES-1];

  // Byte FIFO, entries are {last, data}
  logic [8:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_full, w_empty, w_push, w_pop;
  logic [8:0]    w_head;

  assign w_full   = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = tx_valid && !w_full && !tx_abort;
  assign w_head   = r_mem[r_rptr];
  assign tx_ready = !w_full;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= {tx_last, tx_data};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (tx_abort) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  // Line FSM
  state_t      r_state;
  logic [2:0]  r_bitcnt;
  logic [3:0]  r_flagcnt;
  logic [2:0]  r_ones;
  logic [7:0]  r_byte;
  logic        r_last;
  logic [15:0] r_crc;
  logic [15:0] r_fcs;
  logic [4:0]  r_fcnt;
  logic        r_abort_pend;
  logic        r_d, r_de, r_underrun;

  logic        w_stuff, w_bound, w_start, w_dbit;
  logic [15:0] w_fcs_init;

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
    return (c >> 1) ^ ((c[0] ^ b) ? 16'h8408 : 16'h0000);
  endfunction

  assign w_stuff    = (r_state == S_DATA || r_state == S_FCS) && (r_ones == 3'd5);
  assign w_bound    = (r_state == S_DATA) && !w_stuff && (r_bitcnt == 3'd0);
  assign w_pop      = w_tick && !r_abort_pend && w_bound && !r_last && !w_empty;
  assign w_start    = !w_empty && !tx_abort;
  assign w_dbit     = r_byte[r_bitcnt];
  assign w_fcs_init = ~r_crc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_bitcnt     <= '0;
      r_flagcnt    <= '0;
      r_ones       <= '0;
      r_byte       <= '0;
      r_last       <= 1'b0;
      r_crc        <= 16'hFFFF;
      r_fcs        <= '0;
      r_fcnt       <= '0;
      r_abort_pend <= 1'b0;
      r_d          <= 1'b1;
      r_de         <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (w_tick) begin
        if (r_abort_pend) begin
          r_abort_pend <= 1'b0;
          if (r_state != S_IDLE) begin
            r_state  <= S_ABORT;
            r_d      <= 1'b1;
            r_de     <= 1'b1;
            r_bitcnt <= 3'd1;
          end
        end else begin
          case (r_state)
            S_IDLE: begin
              if (w_start) begin
                r_state   <= S_OPEN;
                r_d       <= FLAG[0];
                r_de      <= 1'b1;
                r_bitcnt  <= 3'd1;
                r_flagcnt <= '0;
              end else begin
                r_d  <= 1'b1;
                r_de <= 1'b0;
              end
            end
            S_OPEN: begin
              r_d      <= FLAG[r_bitcnt];
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                if (r_flagcnt == 4'(PREAMBLE_FLAGS - 1)) begin
                  r_state <= S_DATA;
                  r_ones  <= '0;
                  r_crc   <= 16'hFFFF;
                  r_last  <= 1'b0;
                end else begin
                  r_flagcnt <= r_flagcnt + 4'd1;
                end
              end
            end
            S_DATA: begin
              if (w_stuff) begin
                r_d    <= 1'b0;
                r_ones <= '0;
              end else if (r_bitcnt == 3'd0) begin
                // byte boundary: the first bit of whatever follows goes out on this tick
                if (r_last) begin
                  if (APPEND_FCS != 0) begin
                    r_state <= S_FCS;
                    r_d     <= w_fcs_init[0];
                    r_ones  <= w_fcs_init[0] ? r_ones + 3'd1 : 3'd0;
                    r_fcs   <= w_fcs_init >> 1;
                    r_fcnt  <= 5'd1;
                  end else begin
                    r_state  <= S_CLOSE;
                    r_d      <= FLAG[0];
                    r_bitcnt <= 3'd1;
                  end
                end else if (!w_empty) begin
                  r_byte   <= w_head[7:0];
                  r_last   <= w_head[8];
                  r_d      <= w_head[0];
                  r_ones   <= w_head[0] ? r_ones + 3'd1 : 3'd0;
                  r_crc    <= crc_bit(r_crc, w_head[0]);
                  r_bitcnt <= 3'd1;
                end else begin
                  r_state    <= S_ABORT;
                  r_d        <= 1'b1;
                  r_bitcnt   <= 3'd1;
                  r_underrun <= 1'b1;
                end
              end else begin
                r_d      <= w_dbit;
                r_ones   <= w_dbit ? r_ones + 3'd1 : 3'd0;
                r_crc    <= crc_bit(r_crc, w_dbit);
                r_bitcnt <= r_bitcnt + 3'd1;
              end
            end
            S_FCS: begin
              if (w_stuff) begin
                r_d    <= 1'b0;
                r_ones <= '0;
              end else if (r_fcnt == 5'd16) begin
                r_state  <= S_CLOSE;
                r_d      <= FLAG[0];
                r_bitcnt <= 3'd1;
              end else begin
                r_d    <= r_fcs[0];
                r_ones <= r_fcs[0] ? r_ones + 3'd1 : 3'd0;
                r_fcs  <= r_fcs >> 1;
                r_fcnt <= r_fcnt + 5'd1;
              end
            end
            S_CLOSE: begin
              if (r_bitcnt == 3'd0) begin
                if (w_start) begin
                  r_state   <= S_OPEN;
                  r_d       <= FLAG[0];
                  r_bitcnt  <= 3'd1;
                  r_flagcnt <= '0;
                end else begin
                  r_state <= S_IDLE;
                  r_d     <= 1'b1;
                  r_de    <= 1'b0;
                end
              end else begin
                r_d      <= FLAG[r_bitcnt];
                r_bitcnt <= r_bitcnt + 3'd1;
              end
            end
            S_ABORT: begin
              r_d <= 1'b1;
              if (r_bitcnt == 3'd0) begin
                r_state <= S_IDLE;
                r_de    <= 1'b0;
              end else begin
                r_bitcnt <= r_bitcnt + 3'd1;
              end
            end
            default: begin
              r_state <= S_IDLE;
              r_d     <= 1'b1;
              r_de    <= 1'b0;
            end
          endcase
        end
      end
      if (tx_abort && r_state != S_IDLE) r_abort_pend <= 1'b1;
    end
  end

  assign econet_data_D  = r_d;
  assign econet_data_DE = r_de;
  assign busy           = (r_state != S_IDLE);
  assign underrun       = r_underrun;

endmodule

// File: tb/tb_econet_hdlc_tx.sv
// Directed bench: two transmitters (FCS off / FCS on) share stimulus; expected line bits are
// queued when bytes are pushed and compared on each receiver-side rising Econet clock edge.
module tb_econet_hdlc_tx;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       eclk = 1'b1;
  bit         eclk_run = 1'b0;
  logic [7:0] tx_data;
  logic       tx_last, tx_abort, va, vb;
  logic       rdy_a, d_a, de_a, busy_a, und_a;
  logic       rdy_b, d_b, de_b, busy_b, und_b;

  int         n_total = 0;
  int         n_bad = 0;
  int         und_cnt_a = 0;
  bit         q_a[$];
  bit         q_b[$];
  logic [7:0] fr[$];

  always #5 clock = ~clock;
  initial forever begin
    #100;
    eclk = eclk_run ? ~eclk : 1'b1;
  end

  econet_hdlc_tx #(.FIFO_DEPTH(4), .SYNC_STAGES(2), .PREAMBLE_FLAGS(1), .APPEND_FCS(0)) u_a (
    .clock(clock), .reset_n(reset_n), .tx_data(tx_data), .tx_last(tx_last), .tx_valid(va),
    .tx_ready(rdy_a), .tx_abort(tx_abort), .econet_clock_R(eclk), .econet_data_D(d_a),
    .econet_data_DE(de_a), .busy(busy_a), .underrun(und_a));

  econet_hdlc_tx #(.FIFO_DEPTH(4), .SYNC_STAGES(2), .PREAMBLE_FLAGS(1), .APPEND_FCS(1)) u_b (
    .clock(clock), .reset_n(reset_n), .tx_data(tx_data), .tx_last(tx_last), .tx_valid(vb),
    .tx_ready(rdy_b), .tx_abort(tx_abort), .econet_clock_R(eclk), .econet_data_D(d_b),
    .econet_data_DE(de_b), .busy(busy_b), .underrun(und_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int sel, input bit b);
    if (sel == 0) q_a.push_back(b);
    else q_b.push_back(b);
  endtask

  // Queue one frame's line bits: flag, stuffed fr[] bytes, optional FCS, then flag or 8 ones.
  task automatic model(input int sel, input bit fcs_en, input logic [15:0] fcs, input bit und);
    int         ones;
    logic [7:0] f;
    logic [7:0] by;
    ones = 0;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) put(sel, f[i]);
    for (int k = 0; k < fr.size(); k++) begin
      by = fr[k];
      for (int i = 0; i < 8; i++) begin
        put(sel, by[i]);
        ones = by[i] ? ones + 1 : 0;
        if (ones == 5) begin put(sel, 1'b0); ones = 0; end
      end
    end
    if (und) begin
      for (int i = 0; i < 8; i++) put(sel, 1'b1);
    end else begin
      if (fcs_en) begin
        for (int i = 0; i < 16; i++) begin
          put(sel, fcs[i]);
          ones = fcs[i] ? ones + 1 : 0;
          if (ones == 5) begin put(sel, 1'b0); ones = 0; end
        end
      end
      for (int i = 0; i < 8; i++) put(sel, f[i]);
    end
  endtask

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  task automatic push(input int sel, input logic [7:0] d, input bit last);
    int k;
    k = 0;
    @(negedge clock);
    while (((sel == 0) ? rdy_a : rdy_b) == 1'b0 && k < 5000) begin
      @(negedge clock);
      k++;
    end
    if (k >= 5000) chk("push_ready_timeout", (sel == 0) ? rdy_a : rdy_b, 1);
    tx_data = d;
    tx_last = last;
    if (sel == 0) va = 1'b1; else vb = 1'b1;
    @(negedge clock);
    va = 1'b0;
    vb = 1'b0;
  endtask

  task automatic wait_busy(input int sel, input logic want, input string tag);
    int k;
    k = 0;
    while (get_busy(sel) !== want && k < 6000) begin
      @(negedge clock);
      k++;
    end
    chk(tag, get_busy(sel), want);
  endtask

  // Receiver samples line data on the rising Econet clock edge.
  always @(posedge eclk) begin
    if (de_a === 1'b1) begin
      if (q_a.size() == 0) chk("a_extra_bit", de_a, 0);
      else chk("a_bit", d_a, q_a.pop_front());
    end
    if (de_b === 1'b1) begin
      if (q_b.size() == 0) chk("b_extra_bit", de_b, 0);
      else chk("b_bit", d_b, q_b.pop_front());
    end
  end

  always @(negedge clock) if (und_a === 1'b1) und_cnt_a++;

  initial begin
    tx_data = '0; tx_last = 1'b0; tx_abort = 1'b0; va = 1'b0; vb = 1'b0;
    #23;
    chk("rst_d", d_a, 1);
    chk("rst_de", de_a, 0);
    chk("rst_ready", rdy_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_underrun", und_a, 0);
    chk("rst_de_b", de_b, 0);
    #10 reset_n = 1'b1;
    eclk_run = 1'b1;
    repeat (5) @(negedge clock);

    // single byte, no FCS
    fr.delete(); fr.push_back(8'h42); model(0, 0, 16'h0, 0);
    push(0, 8'h42, 1);
    wait_busy(0, 1, "x42_start");
    wait_busy(0, 0, "x42_end");
    chk("x42_left", q_a.size(), 0);
    chk("x42_de_off", de_a, 0);
    chk("x42_d_idle", d_a, 1);

    // all ones byte exercises stuffing
    fr.delete(); fr.push_back(8'hFF); model(0, 0, 16'h0, 0);
    push(0, 8'hFF, 1);
    wait_busy(0, 1, "xff_start");
    wait_busy(0, 0, "xff_end");
    chk("xff_left", q_a.size(), 0);
    chk("xff_de_off", de_a, 0);

    // back-to-back frames: new opening flag directly after closing flag
    fr.delete(); fr.push_back(8'h42); model(0, 0, 16'h0, 0);
    fr.delete(); fr.push_back(8'h81); model(0, 0, 16'h0, 0);
    push(0, 8'h42, 1);
    push(0, 8'h81, 1);
    wait_busy(0, 1, "b2b_start");
    wait_busy(0, 0, "b2b_end");
    chk("b2b_left", q_a.size(), 0);

    // CRC-16/X.25 check string, FCS 0x906E sent low byte first
    fr.delete();
    for (int i = 0; i < 9; i++) fr.push_back(8'h31 + 8'(i));
    model(1, 1, 16'h906E, 0);
    for (int i = 0; i < 9; i++) push(1, 8'h31 + 8'(i), (i == 8));
    wait_busy(1, 1, "fcs_start");
    wait_busy(1, 0, "fcs_end");
    chk("fcs_left", q_b.size(), 0);
    chk("fcs_de_off", de_b, 0);

    // underrun: byte without last and nothing after it
    und_cnt_a = 0;
    fr.delete(); fr.push_back(8'h7E); model(0, 0, 16'h0, 1);
    push(0, 8'h7E, 0);
    wait_busy(0, 1, "und_start");
    wait_busy(0, 0, "und_end");
    chk("und_left", q_a.size(), 0);
    chk("und_pulses", und_cnt_a, 1);
    chk("und_de_off", de_a, 0);

    // stalled Econet clock: fill FIFO, extra push ignored, then frame carries four bytes only
    eclk_run = 1'b0;
    #250;
    repeat (5) @(negedge clock);
    push(0, 8'h01, 0); push(0, 8'h02, 0); push(0, 8'h03, 0); push(0, 8'h04, 1);
    chk("full_ready", rdy_a, 0);
    tx_data = 8'hAA; tx_last = 1'b1; va = 1'b1;
    @(negedge clock);
    va = 1'b0;
    chk("full_ready_hold", rdy_a, 0);
    chk("stall_busy", busy_a, 0);
    chk("stall_de", de_a, 0);
    fr.delete();
    fr.push_back(8'h01); fr.push_back(8'h02); fr.push_back(8'h03); fr.push_back(8'h04);
    model(0, 0, 16'h0, 0);
    eclk_run = 1'b1;
    wait_busy(0, 1, "full_start");
    wait_busy(0, 0, "full_end");
    chk("full_left", q_a.size(), 0);

    // abort while idle flushes FIFO and drops a coincident push
    eclk_run = 1'b0;
    #250;
    push(0, 8'h11, 0); push(0, 8'h22, 1); push(0, 8'h33, 0); push(0, 8'h44, 1);
    chk("abort_pre_ready", rdy_a, 0);
    @(negedge clock);
    tx_abort = 1'b1; tx_data = 8'h55; tx_last = 1'b1; va = 1'b1;
    @(negedge clock);
    tx_abort = 1'b0; va = 1'b0;
    chk("abort_ready", rdy_a, 1);
    eclk_run = 1'b1;
    repeat (4) @(posedge eclk);
    chk("abort_busy", busy_a, 0);
    chk("abort_de", de_a, 0);

    // reset mid-frame
    fr.delete(); fr.push_back(8'hC3); model(0, 0, 16'h0, 0);
    push(0, 8'hC3, 1);
    wait_busy(0, 1, "mid_start");
    repeat (3) @(posedge eclk);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_de", de_a, 0);
    chk("mid_rst_d", d_a, 1);
    chk("mid_rst_ready", rdy_a, 1);
    chk("mid_rst_busy", busy_a, 0);
    q_a.delete();
    #20 reset_n = 1'b1;
    repeat (3) @(posedge eclk);
    chk("post_rst_de", de_a, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
